// File: rtl/tz_pkg.sv
// Shared helpers for the trailing-zero counter: count width and power-of-two test.
package tz_pkg;

  function automatic int unsigned tz_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned bits);
    return (bits != 0) && ((bits & (bits - 1)) == 0);
  endfunction

endpackage

// File: rtl/tz_if.sv
// Trailing-zeros bundle: word to scan and its registered count.
interface tz_if
  import tz_pkg::*;
#(
  parameter int unsigned BITS = 8
);
  logic [BITS-1:0]           input_num;
  logic [tz_width(BITS)-1:0] trailing_zeros;

  modport counter (input input_num, output trailing_zeros);
  modport user    (output input_num, input trailing_zeros);
endinterface

// File: rtl/tz_reduce.sv
// Recursive combinational trailing-zero tree; power-of-two words split in half,
// other widths split into a power-of-two low part and a recursive remainder.
module tz_reduce
  import tz_pkg::*;
#(
  parameter  int unsigned BITS = 8,
  localparam int unsigned CW   = tz_width(BITS)
) (
  input  logic [BITS-1:0] data,
  output logic [CW-1:0]   count
);

  if (BITS == 1) begin : g_bit
    assign count = ~data;
  end else if (BITS == 2) begin : g_leaf
    always_comb begin
      count = 2'd2;
      if (data[0])      count = 2'd0;
      else if (data[1]) count = 2'd1;
    end
  end else if (is_pow2(BITS)) begin : g_pow2
    localparam int unsigned W  = BITS / 2;
    localparam int unsigned HW = tz_width(W);

    logic [HW-1:0] lo;
    logic [HW-1:0] hi;

    tz_reduce #(.BITS(W)) u_lo (.data(data[W-1:0]),    .count(lo));
    tz_reduce #(.BITS(W)) u_hi (.data(data[BITS-1:W]), .count(hi));

    // Low half decides unless it is all zero; then the high half's count is offset by W.
    assign count = (lo < HW'(W)) ? CW'(lo) : CW'(W) + CW'(hi);
  end else begin : g_split
    localparam int unsigned P  = 1 << (CW - 1);
    localparam int unsigned R  = BITS - P;
    localparam int unsigned LW = tz_width(P);
    localparam int unsigned RW = tz_width(R);

    logic [LW-1:0] lo;
    logic [RW-1:0] hi;

    tz_reduce #(.BITS(P)) u_lo (.data(data[P-1:0]),    .count(lo));
    tz_reduce #(.BITS(R)) u_hi (.data(data[BITS-1:P]), .count(hi));

    assign count = (lo < LW'(P)) ? CW'(lo) : CW'(P) + CW'(hi);
  end

endmodule

// File: rtl/trailing_zeros_counter.sv
// Trailing-zero counter: combinational reduction tree feeding one output register.
module trailing_zeros_counter
  import tz_pkg::*;
#(
  parameter  int unsigned BITS = 8,
  localparam int unsigned CW   = tz_width(BITS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] input_num,
  output logic [CW-1:0]   trailing_zeros
);

  logic [CW-1:0] count_c;

  tz_reduce #(.BITS(BITS)) u_reduce (
    .data  (input_num),
    .count (count_c)
  );

  // Reset wins over the incoming word.
  always_ff @(posedge clk) begin
    if (rst) trailing_zeros <= '0;
    else     trailing_zeros <= count_c;
  end

endmodule

// File: tb/tb_trailing_zeros_counter.sv
// Self-checking bench: several widths run in parallel against a lowest-set-bit model.
module tb_trailing_zeros_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [0:0]   in1;   logic [0:0] o1;
  logic [2:0]   in3;   logic [1:0] o3;
  logic [4:0]   in5;   logic [2:0] o5;
  logic [6:0]   in7;   logic [2:0] o7;
  logic [7:0]   in8;   logic [3:0] o8;
  logic [127:0] in128; logic [7:0] o128;

  trailing_zeros_counter #(.BITS(1))   u_b1   (.clk(clk), .rst(rst), .input_num(in1),   .trailing_zeros(o1));
  trailing_zeros_counter #(.BITS(3))   u_b3   (.clk(clk), .rst(rst), .input_num(in3),   .trailing_zeros(o3));
  trailing_zeros_counter #(.BITS(5))   u_b5   (.clk(clk), .rst(rst), .input_num(in5),   .trailing_zeros(o5));
  trailing_zeros_counter #(.BITS(7))   u_b7   (.clk(clk), .rst(rst), .input_num(in7),   .trailing_zeros(o7));
  trailing_zeros_counter #(.BITS(8))   u_b8   (.clk(clk), .rst(rst), .input_num(in8),   .trailing_zeros(o8));
  trailing_zeros_counter #(.BITS(128)) u_b128 (.clk(clk), .rst(rst), .input_num(in128), .trailing_zeros(o128));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: position of the lowest set bit, or the width when none is set.
  function automatic int unsigned ref_tz(input logic [127:0] v, input int unsigned bits);
    for (int unsigned i = 0; i < bits; i++)
      if (v[i]) return i;
    return bits;
  endfunction

  task automatic check_all();
    check("b1",   32'(o1),   rst ? 0 : ref_tz(128'(in1), 1));
    check("b3",   32'(o3),   rst ? 0 : ref_tz(128'(in3), 3));
    check("b5",   32'(o5),   rst ? 0 : ref_tz(128'(in5), 5));
    check("b7",   32'(o7),   rst ? 0 : ref_tz(128'(in7), 7));
    check("b8",   32'(o8),   rst ? 0 : ref_tz(128'(in8), 8));
    check("b128", 32'(o128), rst ? 0 : ref_tz(in128, 128));
  endtask

  // Inputs settle before the edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_all();
    in1   = 1'($urandom);
    in3   = 3'($urandom);
    in5   = 5'($urandom);
    in7   = 7'($urandom);
    in8   = 8'($urandom);
    in128 = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 2) == 0) begin
      in7   = in7 & 7'($urandom) & 7'($urandom);
      in5   = in5 & 5'($urandom);
      in128 = in128 << $urandom_range(0, 127);
    end
  endtask

  logic [4:0]  vals5 [7] = '{5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000, 5'b01100};
  int unsigned exp5  [7] = '{0, 1, 2, 3, 4, 5, 2};
  logic [7:0]  vals8 [4] = '{8'h00, 8'h80, 8'h01, 8'h40};
  int unsigned exp8  [4] = '{8, 7, 0, 6};

  initial begin
    rst = 1'b1;
    rand_all();
    tick();
    rand_all();
    tick();
    check("rst_b128", 32'(o128), 0);
    check("rst_b8",   32'(o8),   0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      rand_all();
      in5 = vals5[i];
      tick();
      check("b5_sweep", 32'(o5), exp5[i]);
    end

    for (int v = 0; v < 256; v++) begin
      in8 = 8'(v);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      in8 = vals8[i];
      tick();
      check("b8_req", 32'(o8), exp8[i]);
    end

    for (int k = 0; k < 128; k++) begin
      in128 = 128'(1) << k;
      tick();
      check("b128_walk", 32'(o128), 32'(k));
    end
    in128 = '0;
    tick();
    check("b128_zero", 32'(o128), 128);
    in128 = '1;
    tick();
    check("b128_ones", 32'(o128), 0);
    in128 = (128'(1) << 127) | (128'(1) << 64);
    tick();
    check("b128_pair", 32'(o128), 64);

    in1 = 1'b0; in3 = 3'b000;
    tick();
    check("b1_zero", 32'(o1), 1);
    check("b3_000",  32'(o3), 3);
    in1 = 1'b1; in3 = 3'b100;
    tick();
    check("b1_one",  32'(o1), 0);
    check("b3_100",  32'(o3), 2);
    in3 = 3'b010;
    tick();
    check("b3_010",  32'(o3), 1);

    in8 = 8'h10;
    tick();
    check("mid_pre", 32'(o8), 4);
    in8 = 8'h00;
    rst = 1'b1;
    tick();
    check("mid_rst", 32'(o8), 0);
    rst = 1'b0;
    in8 = 8'h03;
    tick();
    check("mid_post", 32'(o8), 0);

    repeat (10000) begin
      rand_all();
      tick();
    end
    in7 = '0;
    tick();
    check("b7_zero", 32'(o7), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
